// File: rtl/ppu_ram_responder_pkg.sv
// Frame constants shared by the PPU and its RAM responder. The request FSM
// state type and small sizing helpers live here as well.
package ppu_ram_responder_pkg;

    // Bit of addr_pins that marks a start cycle while idle.
    localparam int START_BIT        = 0;
    // A response word leaves as this many nibbles.
    localparam int NIBBLES_PER_WORD = 4;
    // Shortest start-to-first-nibble latency the pipeline can honour.
    localparam int MIN_RESP_DELAY   = 7;
    // Width of a backing RAM word.
    localparam int WORD_BITS        = 16;
    // Width of the per-entry response countdown.
    localparam int CD_BITS          = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } req_state_t;

    // Number of nibbles needed to carry 'bits' address bits over 'pins' pins.
    function automatic int nibbles_for(input int bits, input int pins);
        return (bits + pins - 1) / pins;
    endfunction

endpackage

// File: rtl/ppu_ram_resp_fifo.sv
// Two-entry response FIFO. Each entry holds a RAM word and a countdown that
// ages by one every cycle until it reaches 1, the value at which the entry
// is due on the data pins. Entry 0 is always the head.
module ppu_ram_resp_fifo
    import ppu_ram_responder_pkg::*;
#(
    parameter int DATA_W = WORD_BITS,
    parameter int CD_W   = CD_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [CD_W-1:0]   i_push_cd,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CD_W-1:0]   o_head_cd,
    output logic              o_full,
    output logic              o_empty
);

    logic [1:0][DATA_W-1:0] r_data;
    logic [1:0][CD_W-1:0]   r_cd;
    logic [1:0]             r_valid;

    logic [1:0][DATA_W-1:0] w_data_n;
    logic [1:0][CD_W-1:0]   w_cd_n;
    logic [1:0][CD_W-1:0]   w_aged;
    logic [1:0]             w_valid_n;
    logic                   w_do_pop;
    logic                   w_do_push;

    // Next contents: age every countdown, shift on pop, then place a push in
    // the first free slot. A push into a full FIFO with no pop is dropped.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_aged[i] = (r_cd[i] > CD_W'(1)) ? r_cd[i] - CD_W'(1) : r_cd[i];
        end
        w_data_n  = r_data;
        w_cd_n    = w_aged;
        w_valid_n = r_valid;
        w_do_pop  = i_pop && r_valid[0];
        w_do_push = i_push && (!r_valid[1] || w_do_pop);
        if (w_do_pop) begin
            w_data_n[0] = r_data[1];
            w_cd_n[0]   = w_aged[1];
            w_valid_n   = {1'b0, r_valid[1]};
        end
        if (w_do_push) begin
            if (!w_valid_n[0]) begin
                w_data_n[0]  = i_push_data;
                w_cd_n[0]    = i_push_cd;
                w_valid_n[0] = 1'b1;
            end else begin
                w_data_n[1]  = i_push_data;
                w_cd_n[1]    = i_push_cd;
                w_valid_n[1] = 1'b1;
            end
        end
    end

    // Storage registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_cd    <= '0;
            r_valid <= '0;
        end else begin
            r_data  <= w_data_n;
            r_cd    <= w_cd_n;
            r_valid <= w_valid_n;
        end
    end

    assign o_head_data = r_data[0];
    assign o_head_cd   = r_cd[0];
    assign o_full      = r_valid[1];
    assign o_empty     = !r_valid[0];

endmodule

// File: rtl/ppu_ram_responder.sv
// PPU RAM responder. A start cycle (addr_pins[START_BIT]=1 while idle) is
// followed by the address nibbles, MSB first. Five cycles after the start
// the word address is presented to the synchronous RAM with a one-cycle
// read strobe; the returned word is queued and replayed on data_pins LSB
// nibble first, RESP_DELAY cycles after the start.
//
// Handshake: there is no back-pressure. A frame is accepted whenever en is
// high, mem_re is a single-cycle strobe, and mem_rdata is taken exactly one
// cycle after it. dbg_state is 1 while the request FSM is collecting
// address nibbles.
module ppu_ram_responder
    import ppu_ram_responder_pkg::*;
#(
    parameter int RAM_PINS   = 4,
    parameter int ADDR_BITS  = 16,
    parameter int RESP_DELAY = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [RAM_PINS-1:0]  addr_pins,
    output logic [RAM_PINS-1:0]  data_pins,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_re,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic                 dbg_state
);

    localparam int NIB   = nibbles_for(ADDR_BITS, RAM_PINS);
    localparam int SHW   = NIB * RAM_PINS;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int SERW  = WORD_BITS - RAM_PINS;
    localparam int SL_W  = $clog2(NIBBLES_PER_WORD);
    localparam logic [CNT_W-1:0]   LAST_NIB = CNT_W'(NIB - 1);
    localparam logic [SL_W-1:0]    SER_LAST = SL_W'(NIBBLES_PER_WORD - 1);
    // The word is captured MIN_RESP_DELAY-1 cycles after the start, so the
    // remaining wait until its first nibble is RESP_DELAY-(MIN_RESP_DELAY-1).
    localparam logic [CD_BITS-1:0] CD_INIT  = CD_BITS'(RESP_DELAY - MIN_RESP_DELAY + 1);

    req_state_t r_state;
    req_state_t w_state_next;
    logic                 w_shift_en;
    logic                 w_frame_done;

    logic [CNT_W-1:0]     r_nib_cnt;
    logic [SHW-RAM_PINS-1:0] r_shift;
    logic [SHW-1:0]       w_assembled;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic                 r_mem_re;
    logic                 r_rd_pend;

    logic [WORD_BITS-1:0] w_head_data;
    logic [CD_BITS-1:0]   w_head_cd;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;

    logic [SERW-1:0]      r_ser_word;
    logic [SL_W-1:0]      r_ser_left;
    logic [RAM_PINS-1:0]  w_data_nib;
    logic                 r_push_dropped;

    // Request FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Request FSM next state: start bit opens a frame, en low or the last
    // nibble closes it. Nibble values inside a frame never restart it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (en && addr_pins[START_BIT]) w_state_next = ST_ADDR;
            ST_ADDR: if (!en || r_nib_cnt == LAST_NIB) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request FSM outputs: shift a nibble each enabled ADDR cycle and flag
    // the cycle carrying the final nibble.
    always_comb begin
        w_shift_en   = 1'b0;
        w_frame_done = 1'b0;
        if (r_state == ST_ADDR && en) begin
            w_shift_en   = 1'b1;
            w_frame_done = (r_nib_cnt == LAST_NIB);
        end
    end

    assign w_assembled = {r_shift, addr_pins};

    // Address assembly, RAM strobe and the one-cycle RAM latency tracker.
    // Excess high address bits fall off the top of the assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib_cnt  <= '0;
            r_shift    <= '0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_mem_re  <= w_frame_done;
            r_rd_pend <= r_mem_re;
            if (w_frame_done) r_mem_addr <= w_assembled[ADDR_BITS-1:0];
            if (w_shift_en) begin
                r_shift   <= w_assembled[SHW-RAM_PINS-1:0];
                r_nib_cnt <= w_frame_done ? '0 : r_nib_cnt + CNT_W'(1);
            end else begin
                r_nib_cnt <= '0;
            end
        end
    end

    ppu_ram_resp_fifo #(
        .DATA_W (WORD_BITS),
        .CD_W   (CD_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_rd_pend),
        .i_push_data (mem_rdata),
        .i_push_cd   (CD_INIT),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_head_cd   (w_head_cd),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // The head word is due when its countdown reaches 1; it emits its first
    // nibble that cycle and the serializer carries the remaining three.
    assign w_pop = !w_fifo_empty && (w_head_cd == CD_BITS'(1)) && (r_ser_left == '0);

    // Response serializer: holds the upper nibbles of the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_word <= '0;
            r_ser_left <= '0;
        end else if (w_pop) begin
            r_ser_word <= w_head_data[WORD_BITS-1:RAM_PINS];
            r_ser_left <= SER_LAST;
        end else if (r_ser_left != '0) begin
            r_ser_word <= {{RAM_PINS{1'b0}}, r_ser_word[SERW-1:RAM_PINS]};
            r_ser_left <= r_ser_left - SL_W'(1);
        end
    end

    // Data pin mux; driven only from flops, zero when nothing is scheduled.
    always_comb begin
        w_data_nib = '0;
        if (r_ser_left != '0) w_data_nib = r_ser_word[RAM_PINS-1:0];
        else if (w_pop)       w_data_nib = w_head_data[RAM_PINS-1:0];
    end

    // Sticky record of a response lost to a full FIFO (out-of-range delay).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_push_dropped <= 1'b0;
        else        r_push_dropped <= r_push_dropped | (r_rd_pend && w_fifo_full && !w_pop);
    end

    a_no_push_drop: assert property (@(posedge clk) disable iff (!rst_n) !r_push_dropped);

    assign data_pins = w_data_nib;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign dbg_state = (r_state == ST_ADDR);

endmodule

// File: tb/tb_ppu_ram_responder.sv
// Bench for ppu_ram_responder. Two instances (RESP_DELAY 7 and 12) share one
// stimulus stream. A per-cycle schedule of expected pin values is built from
// frame start cycles: strobe at t0+5, word sampled at t0+6, nibbles at
// t0+D..t0+D+3. Reset wipes every scheduled event from that cycle on.
module tb_ppu_ram_responder;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  addr_pins = '0;
    logic [15:0] mem_rdata = '0;

    logic [3:0]  data7, data12;
    logic [15:0] maddr7, maddr12;
    logic        re7, re12, st7, st12;

    always #5 clk = ~clk;

    ppu_ram_responder #(.RAM_PINS(4), .ADDR_BITS(16), .RESP_DELAY(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .addr_pins (addr_pins),
        .data_pins (data7),
        .mem_addr  (maddr7),
        .mem_re    (re7),
        .mem_rdata (mem_rdata),
        .dbg_state (st7)
    );

    ppu_ram_responder #(.RAM_PINS(4), .ADDR_BITS(16), .RESP_DELAY(12)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .addr_pins (addr_pins),
        .data_pins (data12),
        .mem_addr  (maddr12),
        .mem_re    (re12),
        .mem_rdata (mem_rdata),
        .dbg_state (st12)
    );

    // Expected schedule, indexed by cycle number.
    logic [3:0]  exp_d7   [MAXC];
    logic [3:0]  exp_d12  [MAXC];
    logic        exp_re   [MAXC];
    logic [15:0] exp_addr [MAXC];
    logic        pend_rd  [MAXC];
    logic        force_on [MAXC];
    logic [15:0] force_val[MAXC];

    int          cyc = -1;
    int          n_pass = 0;
    int          n_chk = 0;
    bit          m_busy;
    int          m_t0;
    logic [15:0] m_addr;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset(input int from);
        for (int i = from; i < MAXC; i++) begin
            exp_d7[i]   = '0;
            exp_d12[i]  = '0;
            exp_re[i]   = 1'b0;
            exp_addr[i] = '0;
            pend_rd[i]  = 1'b0;
        end
        m_busy = 1'b0;
    endtask

    // Apply the frame rules to the inputs seen in the current cycle.
    task automatic model_step(input logic en_v, input logic [3:0] a, input logic [15:0] rd);
        int t0;
        if (pend_rd[cyc]) begin
            t0 = cyc - 6;
            for (int k = 0; k < 4; k++) begin
                exp_d7[t0 + 7 + k]  = rd[4*k +: 4];
                exp_d12[t0 + 12 + k] = rd[4*k +: 4];
            end
        end
        if (m_busy) begin
            if (!en_v) begin
                m_busy = 1'b0;
            end else begin
                m_addr = {m_addr[11:0], a};
                if (cyc - m_t0 == 4) begin
                    exp_re[cyc + 1]   = 1'b1;
                    exp_addr[cyc + 1] = m_addr;
                    pend_rd[cyc + 2]  = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end else if (en_v && a[0]) begin
            m_busy = 1'b1;
            m_t0   = cyc;
            m_addr = '0;
        end
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling edge.
    task automatic cycle(input bit rst_v, input logic en_v, input logic [3:0] a);
        logic [15:0] rd;
        @(posedge clk);
        #1;
        cyc++;
        rd = force_on[cyc] ? force_val[cyc] : 16'($urandom);
        rst_n     = !rst_v;
        en        = en_v;
        addr_pins = a;
        mem_rdata = rd;
        if (rst_v) model_reset(cyc);
        @(negedge clk);
        check("data7",  {12'h0, data7},  {12'h0, exp_d7[cyc]});
        check("data12", {12'h0, data12}, {12'h0, exp_d12[cyc]});
        check("mem_re7",  {15'h0, re7},  {15'h0, exp_re[cyc]});
        check("mem_re12", {15'h0, re12}, {15'h0, exp_re[cyc]});
        check("state7",  {15'h0, st7},  {15'h0, m_busy});
        check("state12", {15'h0, st12}, {15'h0, m_busy});
        if (exp_re[cyc] || rst_v) begin
            check("mem_addr7",  maddr7,  exp_addr[cyc]);
            check("mem_addr12", maddr12, exp_addr[cyc]);
        end
        if (!rst_v) model_step(en_v, a, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, {3'($urandom), 1'b0});
    endtask

    // Start cycle plus four address nibbles; the RAM returns 'word' at t0+6.
    task automatic frame(input logic [15:0] addr, input logic [15:0] word);
        force_on[cyc + 7]  = 1'b1;
        force_val[cyc + 7] = word;
        cycle(1'b0, 1'b1, {3'($urandom), 1'b1});
        for (int k = 3; k >= 0; k--) cycle(1'b0, 1'b1, addr[4*k +: 4]);
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            force_on[i]  = 1'b0;
            force_val[i] = '0;
        end
        model_reset(0);

        // Reset state.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h1);
        idle(3);

        // Single read: address 1234, word BEEF.
        frame(16'h1234, 16'hBEEF);
        idle(12);

        // Back-to-back frames.
        frame(16'h0001, 16'hA5A5);
        frame(16'h0002, 16'h5A5A);
        idle(14);

        // Three back-to-back frames fill the long-delay FIFO to two entries.
        for (int i = 0; i < 3; i++) frame(16'($urandom), 16'($urandom));
        idle(18);

        // Start-bit value inside a frame is plain address data.
        frame(16'h1111, 16'h0F1E);
        idle(14);

        // en dropped at t0+2, held low (start bits ignored), new start at t0+10.
        cycle(1'b0, 1'b1, 4'h1);
        cycle(1'b0, 1'b1, 4'h7);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'($urandom) | 4'h1);
        frame(16'hC0DE, 16'h1357);
        idle(14);

        // Issued reads survive en going low.
        frame(16'h4321, 16'h2468);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Reset while a response is in flight, then a normal frame.
        frame(16'hABCD, 16'h9876);
        idle(3);
        cycle(1'b1, 1'b0, 4'h0);
        idle(10);
        frame(16'h5555, 16'hFACE);
        idle(14);

        // Reset mid-frame.
        cycle(1'b0, 1'b1, 4'h1);
        cycle(1'b0, 1'b1, 4'h9);
        cycle(1'b1, 1'b1, 4'h9);
        idle(4);
        frame(16'hFFFF, 16'h0001);
        idle(14);

        // Randomized traffic: random nibbles, en dropouts, rare resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) cycle(1'b1, 1'b0, 4'($urandom));
            else       cycle(1'b0, r >= 12, 4'($urandom));
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
